// File: rtl/noc_rr_arbiter_pkg.sv
// rtl/noc_rr_arbiter_pkg.sv - shared helpers for the round-robin arbiter
package noc_rr_arbiter_pkg;

    localparam int MAX_N = 32;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the lowest set bit; callers only pass one-hot or zero vectors.
    function automatic int onehot_to_idx(input logic [MAX_N-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter_fixed_prio_arbiter.sv
// rtl/noc_rr_arbiter_fixed_prio_arbiter.sv - LSB-first one-hot fixed-priority pick
module fixed_prio_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - round-robin arbiter, pointer advances only on update_i
module noc_rr_arbiter
    import noc_rr_arbiter_pkg::*;
#(
    parameter int N_OF_INPUTS = 4
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   update_i,
    input  logic [N_OF_INPUTS-1:0] req_i,
    output logic [N_OF_INPUTS-1:0] grant_o
);

    localparam int PTR_W = ptr_width(N_OF_INPUTS);

    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       next_ptr;
    logic [N_OF_INPUTS-1:0] mask;
    logic [N_OF_INPUTS-1:0] masked_req;
    logic [N_OF_INPUTS-1:0] masked_grant;
    logic [N_OF_INPUTS-1:0] plain_grant;
    int                     grant_idx;

    // Mask keeps requesters at or above ptr; if none remain the scan wraps to the unmasked pick.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_OF_INPUTS; i++) begin
            mask[i] = (PTR_W'(i) >= ptr);
        end
    end

    assign masked_req = req_i & mask;

    fixed_prio_arbiter #(.N(N_OF_INPUTS)) u_masked (
        .req   (masked_req),
        .grant (masked_grant)
    );

    fixed_prio_arbiter #(.N(N_OF_INPUTS)) u_plain (
        .req   (req_i),
        .grant (plain_grant)
    );

    assign grant_o = (|masked_req) ? masked_grant : plain_grant;

    always_comb begin
        grant_idx = onehot_to_idx(MAX_N'(grant_o));
        if (grant_idx == N_OF_INPUTS - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = PTR_W'(grant_idx + 1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ptr <= '0;
        end else if (update_i && (|grant_o)) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// tb/tb_noc_rr_arbiter.sv - directed table-driven bench for noc_rr_arbiter
module tb_noc_rr_arbiter;

    logic       clk;
    logic       arst;
    logic       update_i;
    logic [3:0] req_i;
    logic [3:0] grant_o;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] req;
        logic       upd;
        logic [3:0] exp_grant;
    } vec_t;

    vec_t vecs[$];

    noc_rr_arbiter #(.N_OF_INPUTS(4)) dut (
        .clk      (clk),
        .arst     (arst),
        .update_i (update_i),
        .req_i    (req_i),
        .grant_o  (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] exp);
        checks++;
        if (grant_o !== exp) begin
            errors++;
            $display("FAIL %s: grant_o=%b expected=%b", name, grant_o, exp);
        end
    endtask

    // Drive at negedge, check before the rising edge, drop update after it.
    task automatic apply(input logic [3:0] req, input logic upd, input logic [3:0] exp,
                         input string name);
        @(negedge clk);
        req_i    = req;
        update_i = upd;
        #1;
        check(name, exp);
        @(posedge clk);
        #1;
        update_i = 1'b0;
    endtask

    function automatic void add(input logic [3:0] req, input logic upd, input logic [3:0] exp);
        vec_t v;
        v.req       = req;
        v.upd       = upd;
        v.exp_grant = exp;
        vecs.push_back(v);
    endfunction

    always @(negedge clk) begin
        if (!arst) begin
            checks++;
            if (!$onehot0(grant_o) || ((grant_o & ~req_i) != 4'b0) ||
                ((req_i != 4'b0) && (grant_o == 4'b0))) begin
                errors++;
                $display("FAIL invariant: grant_o=%b req_i=%b", grant_o, req_i);
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        arst     = 1'b1;
        update_i = 1'b0;
        req_i    = 4'b0000;

        #1;
        check("reset_zero_req", 4'b0000);
        req_i = 4'b1111;
        #1;
        check("reset_all_req", 4'b0001);
        update_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("reset_holds_ptr", 4'b0001);
        @(negedge clk);
        update_i = 1'b0;
        arst     = 1'b0;

        // singles, ptr 0 -> 1 -> 2 -> 3 -> 0, then empty update keeps ptr 0
        add(4'b0001, 1'b1, 4'b0001);
        add(4'b0010, 1'b1, 4'b0010);
        add(4'b0100, 1'b1, 4'b0100);
        add(4'b1000, 1'b1, 4'b1000);
        add(4'b0000, 1'b1, 4'b0000);
        add(4'b1111, 1'b0, 4'b0001);
        // two requesters
        add(4'b1010, 1'b1, 4'b0010);
        add(4'b1010, 1'b1, 4'b1000);
        add(4'b1010, 1'b1, 4'b0010);
        // ptr=2: empty update must not move it
        add(4'b0000, 1'b1, 4'b0000);
        add(4'b0110, 1'b0, 4'b0100);
        add(4'b0011, 1'b0, 4'b0001);
        add(4'b1000, 1'b1, 4'b1000);
        // three requesters from ptr 0
        for (int k = 0; k < 2; k++) begin
            add(4'b1011, 1'b1, 4'b0001);
            add(4'b1011, 1'b1, 4'b0010);
            add(4'b1011, 1'b1, 4'b1000);
        end

        foreach (vecs[i]) begin
            apply(vecs[i].req, vecs[i].upd, vecs[i].exp_grant, $sformatf("vec%0d", i));
        end

        // all four requesting: strict rotation with no skips
        for (int k = 0; k < 20; k++) begin
            logic [3:0] exp;
            exp = 4'b0001 << (k % 4);
            apply(4'b1111, 1'b1, exp, $sformatf("rotate%0d", k));
        end

        // move ptr to 2, then hold without updates
        apply(4'b1111, 1'b1, 4'b0001, "to_ptr1");
        apply(4'b1111, 1'b1, 4'b0010, "to_ptr2");
        for (int k = 0; k < 10; k++) begin
            apply(4'b1111, 1'b0, 4'b0100, $sformatf("hold%0d", k));
        end

        // asynchronous reset mid-cycle with ptr=2
        @(posedge clk);
        #3;
        arst = 1'b1;
        #1;
        check("arst_async", 4'b0001);
        @(negedge clk);
        arst = 1'b0;
        #1;
        check("after_arst", 4'b0001);
        apply(4'b1111, 1'b1, 4'b0001, "post_arst_upd");
        apply(4'b1111, 1'b0, 4'b0010, "post_arst_ptr1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
